morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter: UNIT_CYCLES, default 4, clock cycles per Morse time unit; legal range 1..65535.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: code  input  5  digit pattern from the digit encoder; bit=1 dot, bit=0 dash; code[4] sent first.
REQ-005 Port: start  input  1  load request; sampled on rising clk edge.
REQ-006 Port: tx  output  1  key line; 1 = tone/LED on (mark), 0 = off (space).
REQ-007 Port: busy  output  1  high while a character is in progress.
REQ-008 Port: done  output  1  one-cycle pulse at character completion.

Function
REQ-009 All outputs SHALL be registered; all state changes on rising clk edge only.
REQ-010 States SHALL be IDLE, MARK, SPACE, GAP; in IDLE, tx=0 and busy=0.
REQ-011 start=1 at an edge while in IDLE SHALL latch code into a 5-bit shift register, clear symbol count to 0, enter MARK; tx=1 and busy=1 from that edge.
REQ-012 start while busy=1 SHALL be ignored; code and transmission SHALL be unaffected.
REQ-013 code SHALL be sampled only at the accepting edge; later code changes have no effect.
REQ-014 MARK SHALL last 1 unit (UNIT_CYCLES clocks) for a dot and 3 units for a dash, per current MSB of the shift register.
REQ-015 After MARK of symbols 1-4: shift register shifts left one bit, symbol count increments, enter SPACE (tx=0) for exactly 1 unit, then MARK of next symbol.
REQ-016 After MARK of symbol 5: enter GAP (macro present) or complete directly (macro absent), per REQ-025/026.
REQ-017 Completion SHALL drop busy to 0 and raise done for exactly one cycle at the same edge, returning to IDLE.
REQ-018 start=1 in the cycle where done=1 SHALL be accepted (busy already 0); next character begins with no extra dead cycle.
REQ-019 Unit timer SHALL count 0..UNIT_CYCLES-1, restarted on every state entry; UNIT_CYCLES=1 SHALL give 1-clock units with no skipped or merged units.
REQ-020 Exactly 5 symbols per character; symbol counter SHALL NOT wrap past 5.

Reset
REQ-021 reset=1 SHALL immediately, independent of clk, force state IDLE, tx=0, busy=0, done=0, timer and symbol count to 0.
REQ-022 Reset mid-character SHALL abort it with no done pulse; the aborted character SHALL NOT resume.
REQ-023 First edge after reset deassertion SHALL accept start normally.
REQ-024 Shift register content after reset is don't-care; it SHALL never reach tx without a new start.

Configuration
REQ-025 Macro MORSE_TX_CHARGAP_EN defined: after symbol 5 MARK, GAP state holds tx=0, busy=1 for 3 units, then completion; consecutive characters spaced per Morse inter-character rule.
REQ-026 Macro MORSE_TX_CHARGAP_EN undefined: GAP state absent; completion occurs at the edge ending symbol 5 MARK; spacing is the upstream's responsibility.

Verification (UNIT_CYCLES=2 unless stated)
REQ-027 code=5'b10000 ("1"), start 1 cycle, macro on -> tx high 2, low 2, then (high 6, low 2) x3, high 6, low 6 more; done at cycle 40 after accept; busy high 40 cycles.
REQ-028 code=5'b00000 ("0"), macro off -> five 6-cycle marks separated by 2-cycle spaces; busy high 38 cycles; done single pulse.
REQ-029 start held high continuously with code=5'b11111, macro on -> back-to-back characters, each 5 x 2-cycle marks, 4 x 2-cycle spaces, 6-cycle gap; busy low exactly 1 cycle between characters, coinciding with done.
REQ-030 During "1" transmission, pulse start with code=5'b00000 mid-character -> ignored; waveform identical to REQ-027.
REQ-031 Assert reset asynchronously during 3rd symbol MARK -> tx, busy drop within same cycle without clock edge; no done; new start afterward transmits fresh code correctly.
REQ-032 UNIT_CYCLES=1, code=5'b01010 -> mark lengths 3,1,3,1,3 clocks with 1-clock spaces; total busy 15 cycles (macro off).

Source files
------------

// File: rtl/morse_tx.sv
// ---------------------------------------------------------------------------
// morse_tx : serialises one 5-symbol Morse digit onto a key line.
//
// A character is loaded from `code` on an accepted `start` and sent MSB
// first. A 1 bit is a dot (1 unit of mark) and a 0 bit is a dash (3 units).
// Symbols are separated by a 1-unit space. One unit is UNIT_CYCLES clocks.
//
// Optional feature (compile-time macro MORSE_TX_CHARGAP_EN):
//    defined   - a 3-unit inter-character gap follows the last mark, with
//                busy still high, before the character completes.
//    undefined - the character completes at the end of the last mark.
//
// Parameters:
//    UNIT_CYCLES  clocks per Morse time unit (1..65535)
//
// Ports:
//    clk    in   rising-edge system clock
//    reset  in   asynchronous, active-high reset
//    code   in   [4:0] digit pattern, bit=1 dot, bit=0 dash, code[4] first
//    start  in   load request, honoured only while idle
//    tx     out  key line, 1 = mark (tone on), 0 = space
//    busy   out  high while a character is in progress
//    done   out  one-cycle pulse at character completion
// ---------------------------------------------------------------------------
module morse_tx #(
   parameter int unsigned UNIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] code,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [15:0] UNIT_LAST = 16'(UNIT_CYCLES - 1);

   state_t      state, state_next;
   logic [4:0]  shift_reg, shift_next;
   logic [2:0]  sym_cnt, sym_next;
   logic [15:0] timer, timer_next;
   logic [1:0]  unit_cnt, unit_next;
   logic        tx_next, busy_next, done_next;

   logic        unit_end;
   logic        mark_last_unit;

   // Unit boundary, and whether the unit just ending is the final one of the
   // current mark (dot = single unit, dash = third unit).
   assign unit_end       = (timer == UNIT_LAST);
   assign mark_last_unit = shift_reg[4] ? (unit_cnt == 2'd0) : (unit_cnt == 2'd2);

   // State and output registers; reset abandons any character in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= 5'd0;
         sym_cnt   <= 3'd0;
         timer     <= 16'd0;
         unit_cnt  <= 2'd0;
         tx        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         sym_cnt   <= sym_next;
         timer     <= timer_next;
         unit_cnt  <= unit_next;
         tx        <= tx_next;
         busy      <= busy_next;
         done      <= done_next;
      end
   end

   // Next-state logic. The unit timer restarts on every unit boundary, so a
   // new state is always entered with the timer at zero. Outputs are derived
   // from the next state so they appear registered in the same cycle the
   // state is entered.
   always_comb begin
      state_next = state;
      shift_next = shift_reg;
      sym_next   = sym_cnt;
      timer_next = timer + 16'd1;
      unit_next  = unit_cnt;
      done_next  = 1'b0;

      case (state)
         IDLE: begin
            timer_next = 16'd0;
            unit_next  = 2'd0;
            if (start) begin
               shift_next = code;
               sym_next   = 3'd0;
               state_next = MARK;
            end
         end

         MARK: begin
            if (unit_end) begin
               timer_next = 16'd0;
               if (mark_last_unit) begin
                  unit_next = 2'd0;
                  if (sym_cnt < 3'd4) begin
                     shift_next = {shift_reg[3:0], 1'b0};
                     sym_next   = sym_cnt + 3'd1;
                     state_next = SPACE;
                  end else begin
`ifdef MORSE_TX_CHARGAP_EN
                     state_next = GAP;
`else
                     state_next = IDLE;
                     done_next  = 1'b1;
`endif
                  end
               end else begin
                  unit_next = unit_cnt + 2'd1;
               end
            end
         end

         SPACE: begin
            if (unit_end) begin
               timer_next = 16'd0;
               state_next = MARK;
            end
         end

         GAP: begin
            if (unit_end) begin
               timer_next = 16'd0;
               if (unit_cnt == 2'd2) begin
                  unit_next  = 2'd0;
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  unit_next = unit_cnt + 2'd1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      tx_next   = (state_next == MARK);
      busy_next = (state_next != IDLE);
   end

endmodule

// File: tb/tb_morse_tx.sv
// ---------------------------------------------------------------------------
// tb_morse_tx : self-checking bench for morse_tx.
//
// Two instances are exercised: one with UNIT_CYCLES=2 and one with
// UNIT_CYCLES=1. Expected key-line waveforms are built per character from
// the Morse timing rules (dot 1 unit, dash 3 units, 1-unit symbol space,
// optional 3-unit character gap when MORSE_TX_CHARGAP_EN is defined).
// ---------------------------------------------------------------------------
module tb_morse_tx;

   logic       clk;
   logic       reset;
   logic [4:0] code2, code1;
   logic       start2, start1;
   logic       tx2, busy2, done2;
   logic       tx1, busy1, done1;

   int n_checks = 0;
   int n_fail   = 0;

   bit exp_q[$];

   morse_tx #(.UNIT_CYCLES(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .code  (code2),
      .start (start2),
      .tx    (tx2),
      .busy  (busy2),
      .done  (done2)
   );

   morse_tx #(.UNIT_CYCLES(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .code  (code1),
      .start (start1),
      .tx    (tx1),
      .busy  (busy1),
      .done  (done1)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

`ifdef MORSE_TX_CHARGAP_EN
   localparam int GAP_UNITS = 3;
`else
   localparam int GAP_UNITS = 0;
`endif

   // Build the per-cycle key-line waveform of one character after accept.
   function automatic void buildExpected(input logic [4:0] c, input int u);
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         int mark_len;
         mark_len = (c[4-i] ? 1 : 3) * u;
         for (int k = 0; k < mark_len; k++) exp_q.push_back(1'b1);
         if (i < 4)
            for (int k = 0; k < u; k++) exp_q.push_back(1'b0);
      end
      for (int k = 0; k < GAP_UNITS * u; k++) exp_q.push_back(1'b0);
   endfunction

   function automatic logic [2:0] observe(input int sel);
      return (sel == 2) ? {tx2, busy2, done2} : {tx1, busy1, done1};
   endfunction

   task automatic applyStimulus(input int sel, input logic s, input logic [4:0] c);
      if (sel == 2) begin
         start2 = s;
         code2  = c;
      end else begin
         start1 = s;
         code1  = c;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] observed,
                              input logic [2:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed {tx,busy,done}=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Send one character and check every cycle up to and including the done
   // cycle. Called at a falling edge. The code input is scrambled while the
   // character is running. abort_at >= 0 fires an asynchronous reset at that
   // cycle instead of running to completion.
   task automatic runChar(input int sel, input logic [4:0] c, input bit hold,
                          input bit mid_start, input int abort_at, input string tag);
      int len;
      buildExpected(c, (sel == 2) ? 2 : 1);
      len = exp_q.size();
      applyStimulus(sel, 1'b1, c);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s cyc%0d", tag, k), observe(sel), {exp_q[k], 2'b10});
         if (abort_at == k) begin
            #2 reset = 1'b1;
            #1 checkOutput($sformatf("%s async-reset", tag), observe(sel), 3'b000);
            @(negedge clk);
            reset = 1'b0;
            applyStimulus(sel, 1'b0, 5'($urandom));
            return;
         end
         if (mid_start && k == 5)
            applyStimulus(sel, 1'b1, 5'b00000);
         else
            applyStimulus(sel, hold, 5'($urandom));
      end
      @(negedge clk);
      checkOutput($sformatf("%s done", tag), observe(sel), 3'b001);
      if (hold) applyStimulus(sel, 1'b1, c);
      else      applyStimulus(sel, 1'b0, 5'($urandom));
   endtask

   // Idle cycles: key line off, not busy, no stray done pulse.
   task automatic checkIdle(input int sel, input int cycles, input string tag);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         checkOutput($sformatf("%s idle%0d", tag, k), observe(sel), 3'b000);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(2, 1'b0, 5'd0);
      applyStimulus(1, 1'b0, 5'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset u2", observe(2), 3'b000);
      checkOutput("reset u1", observe(1), 3'b000);
      reset = 1'b0;

      $display("[TB] digit 1 straight after reset release");
      runChar(2, 5'b10000, 1'b0, 1'b0, -1, "digit1");
      checkIdle(2, 2, "after1");

      $display("[TB] digit 0");
      runChar(2, 5'b00000, 1'b0, 1'b0, -1, "digit0");
      checkIdle(2, 1, "after0");

      $display("[TB] digit 1 with ignored mid-character start");
      runChar(2, 5'b10000, 1'b0, 1'b1, -1, "ignore");
      checkIdle(2, 1, "afterIgnore");

      $display("[TB] back-to-back with start held");
      runChar(2, 5'b11111, 1'b1, 1'b0, -1, "b2b-a");
      runChar(2, 5'b11111, 1'b1, 1'b0, -1, "b2b-b");
      runChar(2, 5'b11111, 1'b0, 1'b0, -1, "b2b-c");
      checkIdle(2, 2, "afterB2b");

      $display("[TB] asynchronous reset during third mark");
      runChar(2, 5'b10000, 1'b0, 1'b0, 13, "abort");
      checkIdle(2, 8, "afterAbort");
      runChar(2, 5'($urandom), 1'b0, 1'b0, -1, "fresh");
      checkIdle(2, 1, "afterFresh");

      $display("[TB] single-clock units");
      runChar(1, 5'b01010, 1'b0, 1'b0, -1, "u1-01010");
      checkIdle(1, 1, "afterU1");

      $display("[TB] random characters");
      for (int n = 0; n < 6; n++) begin
         runChar(2, 5'($urandom), 1'b0, 1'b0, -1, $sformatf("rnd2-%0d", n));
         checkIdle(2, $urandom_range(0, 2), $sformatf("rnd2gap-%0d", n));
         runChar(1, 5'($urandom), 1'b0, 1'b0, -1, $sformatf("rnd1-%0d", n));
         checkIdle(1, $urandom_range(0, 2), $sformatf("rnd1gap-%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
